// File: rtl/dmem_pkg.sv
// Shared constants and strobe decoding for the RV32I byte-addressable data memory.
package dmem_pkg;

  localparam int unsigned DMEM_ADDR_W = 7;

  localparam logic [2:0] STRB_WORD        = 3'b000;
  localparam logic [2:0] STRB_HALF_LO     = 3'b001;
  localparam logic [2:0] STRB_HALF_HI     = 3'b011;
  localparam logic       STRB_BYTE_PREFIX = 1'b1;

  // Illegal code 3'b010 maps to no lanes so the store is dropped.
  function automatic logic [3:0] strb_to_be(input logic [2:0] strb);
    logic [3:0] be;
    be = 4'b0000;
    if (strb[2] == STRB_BYTE_PREFIX) begin
      be = 4'b0001 << strb[1:0];
    end else begin
      case (strb)
        STRB_WORD:    be = 4'b1111;
        STRB_HALF_LO: be = 4'b0011;
        STRB_HALF_HI: be = 4'b1100;
        default:      be = 4'b0000;
      endcase
    end
    return be;
  endfunction

endpackage

// File: rtl/rv_byte_data_mem_if.sv
// Read/write port bundle for rv_byte_data_mem; the datapath is master, the memory slave.
interface rv_byte_data_mem_if
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W
);
  logic [ADDR_W-1:0] rd_addr0;
  logic [31:0]       rd_dout0;
  logic              we0;
  logic [ADDR_W-1:0] wr_addr0;
  logic [31:0]       wr_din0;
  logic [2:0]        wr_strb;

  modport master (
    output rd_addr0, we0, wr_addr0, wr_din0, wr_strb,
    input  rd_dout0
  );

  modport slave (
    input  rd_addr0, we0, wr_addr0, wr_din0, wr_strb,
    output rd_dout0
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Turns a right-aligned store and its strobe code into byte enables and lane-replicated data.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  strb_i,
  input  logic [31:0] din_i,
  output logic [3:0]  be_o,
  output logic [31:0] data_o
);

  always_comb begin
    be_o   = strb_to_be(strb_i);
    data_o = din_i;
    if (strb_i[2] == STRB_BYTE_PREFIX) begin
      data_o = {4{din_i[7:0]}};
    end else if (strb_i[0]) begin
      data_o = {2{din_i[15:0]}};
    end
  end

endmodule

// File: rtl/rv_byte_data_mem.sv
// 2**ADDR_W x 32 data memory with byte-lane stores and asynchronous clear.
// Define DMEM_REG_READ_EN for a registered (1-cycle, read-first) read port.
module rv_byte_data_mem
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
  input  logic                clk,
  input  logic                rst,
  rv_byte_data_mem_if.slave   bus
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [31:0] mem_q [Depth];
  logic [3:0]  be;
  logic [31:0] lane_data;
  logic [31:0] merged;

  dmem_lane_align u_lane_align (
    .strb_i (bus.wr_strb),
    .din_i  (bus.wr_din0),
    .be_o   (be),
    .data_o (lane_data)
  );

  always_comb begin
    merged = mem_q[bus.wr_addr0];
    for (int b = 0; b < 4; b++) begin
      if (be[b]) merged[8*b +: 8] = lane_data[8*b +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q <= '{default: '0};
    end else if (bus.we0 && (be != 4'b0000)) begin
      mem_q[bus.wr_addr0] <= merged;
    end
  end

`ifdef DMEM_REG_READ_EN
  logic [31:0] rd_q;

  // Samples the pre-edge array contents, so a same-edge write reads old data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_q <= '0;
    else      rd_q <= mem_q[bus.rd_addr0];
  end

  assign bus.rd_dout0 = rd_q;
`else
  assign bus.rd_dout0 = mem_q[bus.rd_addr0];
`endif

endmodule

// File: tb/tb_rv_byte_data_mem.sv
// Self-checking bench for rv_byte_data_mem against a byte-array reference model.
// Also covers the DMEM_REG_READ_EN build when that macro is defined.
module tb_rv_byte_data_mem;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  logic [7:0] mb [512];

  rv_byte_data_mem_if #(.ADDR_W(7)) dif ();

  rv_byte_data_mem #(.ADDR_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_word(input int a);
    return {mb[4*a+3], mb[4*a+2], mb[4*a+1], mb[4*a]};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 512; i++) mb[i] = 8'h00;
  endtask

  task automatic model_store(input int a, input logic [31:0] din, input logic [2:0] strb);
    if (strb[2]) begin
      mb[4*a + int'(strb[1:0])] = din[7:0];
    end else if (strb == 3'b000) begin
      for (int k = 0; k < 4; k++) mb[4*a+k] = din[8*k +: 8];
    end else if (strb == 3'b001) begin
      mb[4*a]   = din[7:0];
      mb[4*a+1] = din[15:8];
    end else if (strb == 3'b011) begin
      mb[4*a+2] = din[7:0];
      mb[4*a+3] = din[15:8];
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drives one write cycle; returns 1 time unit after the capturing edge with we0 low.
  task automatic wr(input int a, input logic [31:0] din, input logic [2:0] strb,
                    input logic we);
    dif.we0      = we;
    dif.wr_addr0 = 7'(a);
    dif.wr_din0  = din;
    dif.wr_strb  = strb;
    @(posedge clk);
    #1;
    dif.we0 = 1'b0;
    if (we) model_store(a, din, strb);
  endtask

  task automatic rd(input int a, output logic [31:0] d);
    dif.rd_addr0 = 7'(a);
`ifdef DMEM_REG_READ_EN
    @(posedge clk);
    #1;
`else
    #1;
`endif
    d = dif.rd_dout0;
  endtask

  initial begin
    logic [31:0] d;
    int a;
    logic [2:0] s;
    logic [31:0] v;
    logic w;
    checks = 0;
    errors = 0;
    model_clear();
    rst          = 1'b0;
    dif.rd_addr0 = '0;
    dif.we0      = 1'b0;
    dif.wr_addr0 = '0;
    dif.wr_din0  = '0;
    dif.wr_strb  = 3'b000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", dif.rd_dout0, 32'h0);
    rst = 1'b1;
    rd(64, d);
    chk("post_reset_read", d, model_word(64));

    // Reset clears memory without a clock edge.
    wr(0, 32'hFFFF_FFFF, 3'b000, 1'b1);
    wr(127, 32'hFFFF_FFFF, 3'b000, 1'b1);
    rd(127, d);
    chk("preload_127", d, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
    dif.rd_addr0 = 7'd0;
    #1;
    chk("async_clear_0", dif.rd_dout0, 32'h0);
    dif.rd_addr0 = 7'd127;
    #1;
    chk("async_clear_127", dif.rd_dout0, 32'h0);
    rst = 1'b1;
    rd(0, d);
    chk("cleared_0_after", d, 32'h0);

    // Word write; no bypass before the edge.
`ifndef DMEM_REG_READ_EN
    @(posedge clk);
    #1;
    dif.rd_addr0 = 7'd5;
    dif.we0      = 1'b1;
    dif.wr_addr0 = 7'd5;
    dif.wr_din0  = 32'hDEAD_BEEF;
    dif.wr_strb  = 3'b000;
    #1;
    chk("no_bypass", dif.rd_dout0, 32'h0);
`endif
    wr(5, 32'hDEAD_BEEF, 3'b000, 1'b1);
    rd(5, d);
    chk("word_write", d, 32'hDEAD_BEEF);

    // Halfword writes replicate and mask into the right lanes.
    wr(5, 32'h0000_1234, 3'b011, 1'b1);
    rd(5, d);
    chk("half_hi", d, 32'h1234_BEEF);
    wr(5, 32'hFFFF_5678, 3'b001, 1'b1);
    rd(5, d);
    chk("half_lo", d, 32'h1234_5678);

    // Byte writes, upper din bits ignored.
    wr(9, 32'hABCD_EF11, 3'b100, 1'b1);
    wr(9, 32'h0000_0022, 3'b101, 1'b1);
    wr(9, 32'h0000_0033, 3'b110, 1'b1);
    rd(9, d);
    chk("bytes_partial", d, 32'h0033_2211);
    wr(9, 32'h0000_0044, 3'b111, 1'b1);
    rd(9, d);
    chk("bytes_all", d, 32'h4433_2211);

    // Guards: we0 low, illegal strobe, reset during write.
    wr(9, 32'h5555_5555, 3'b000, 1'b0);
    rd(9, d);
    chk("we0_low", d, 32'h4433_2211);
    wr(9, 32'h5555_5555, 3'b010, 1'b1);
    rd(9, d);
    chk("illegal_strb", d, 32'h4433_2211);
    @(posedge clk);
    #1;
    dif.we0      = 1'b1;
    dif.wr_addr0 = 7'd20;
    dif.wr_din0  = 32'h1234_5678;
    dif.wr_strb  = 3'b000;
    rst          = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    rst     = 1'b1;
    dif.we0 = 1'b0;
    rd(20, d);
    chk("rst_beats_write", d, 32'h0);
    rd(9, d);
    chk("rst_cleared_9", d, 32'h0);

`ifdef DMEM_REG_READ_EN
    // Registered read: new data one edge after the write edge.
    dif.rd_addr0 = 7'd3;
    @(posedge clk);
    #1;
    v = model_word(3);
    wr(3, 32'hCAFE_F00D, 3'b000, 1'b1);
    chk("regread_write_edge", dif.rd_dout0, v);
    @(posedge clk);
    #1;
    chk("regread_next_edge", dif.rd_dout0, 32'hCAFE_F00D);
`endif

    // Randomized stores against the byte model.
    for (int n = 0; n < 150; n++) begin
      a = int'($urandom_range(0, 127));
      s = 3'($urandom_range(0, 7));
      v = $urandom;
      w = ($urandom_range(0, 3) != 0);
      wr(a, v, s, w);
      if ($urandom_range(0, 1) == 0) a = int'($urandom_range(0, 127));
      rd(a, d);
      chk($sformatf("rand_%0d_addr%0d", n, a), d, model_word(a));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
